// File: rtl/vrf_read_responder.sv
// VRF read responder: accepts tagged read requests, drives one synchronous-read
// bank SRAM port and returns tagged data through a credit-limited response FIFO.
module vrf_read_responder #(
  parameter int VS_W        = 5,
  parameter int OFFSET_W    = 6,
  parameter int SRC_W       = 4,
  parameter int IDX_W       = 3,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 2,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [VS_W-1:0]          req_vs,
  input  logic [OFFSET_W-1:0]      req_offset,
  input  logic [SRC_W-1:0]         req_readSource,
  input  logic [IDX_W-1:0]         req_instructionIndex,
  output logic                     ram_ren,
  output logic [VS_W+OFFSET_W-1:0] ram_addr,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_data,
  output logic [SRC_W-1:0]         resp_readSource,
  output logic [IDX_W-1:0]         resp_instructionIndex,
  output logic                     idle
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int ENT_W = DATA_W + SRC_W + IDX_W;

  logic [CNT_W-1:0]       used;
  logic                   accept;
  logic                   push;
  logic                   pop;

  logic [RAM_LATENCY-1:0] pipe_vld;
  logic [SRC_W-1:0]       pipe_src [RAM_LATENCY];
  logic [IDX_W-1:0]       pipe_idx [RAM_LATENCY];

  logic [ENT_W-1:0]       fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover both the SRAM pipe and the FIFO, so a read is only issued
  // when a FIFO slot is guaranteed to be free when its data lands.
  assign req_ready = (used < CNT_W'(RESP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign ram_ren   = accept;
  assign ram_addr  = {req_vs, req_offset};

  assign push       = pipe_vld[RAM_LATENCY-1];
  assign resp_valid = (fifo_cnt != '0);
  assign pop        = resp_valid & resp_ready;
  assign idle       = (used == '0);

  assign {resp_data, resp_readSource, resp_instructionIndex} = fifo_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      used     <= '0;
      pipe_vld <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_src[i] <= '0;
        pipe_idx[i] <= '0;
      end
    end else begin
      used <= used + CNT_W'(accept) - CNT_W'(pop);

      pipe_vld[0] <= accept;
      pipe_src[0] <= req_readSource;
      pipe_idx[0] <= req_instructionIndex;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_src[i] <= pipe_src[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: occupancy and pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= {ram_rdata, pipe_src[RAM_LATENCY-1], pipe_idx[RAM_LATENCY-1]};
  end

`ifndef SYNTHESIS
  a_fifo_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(push && !pop && fifo_cnt == CNT_W'(RESP_DEPTH)));
  a_fifo_underflow: assert property (@(posedge clock) disable iff (!reset)
    !(pop && fifo_cnt == '0));
  a_credit_range: assert property (@(posedge clock) disable iff (!reset)
    used <= CNT_W'(RESP_DEPTH));
  a_credit_consistent: assert property (@(posedge clock) disable iff (!reset)
    used == CNT_W'($countones(pipe_vld)) + fifo_cnt);
`endif

endmodule

// File: tb/tb_vrf_read_responder.sv
// Scoreboard bench for vrf_read_responder: directed scenarios plus a random
// phase, with a bench-side SRAM model supplying read data.
module tb_vrf_read_responder;

  localparam int VS_W = 5, OFFSET_W = 6, SRC_W = 4, IDX_W = 3, DATA_W = 32;
  localparam int RAM_LATENCY = 2, RESP_DEPTH = 4;
  localparam int ADDR_W = VS_W + OFFSET_W;

  logic                clock = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [VS_W-1:0]     req_vs;
  logic [OFFSET_W-1:0] req_offset;
  logic [SRC_W-1:0]    req_readSource;
  logic [IDX_W-1:0]    req_instructionIndex;
  logic                ram_ren;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_data;
  logic [SRC_W-1:0]    resp_readSource;
  logic [IDX_W-1:0]    resp_instructionIndex;
  logic                idle;

  always #5 clock = ~clock;

  vrf_read_responder #(
    .VS_W(VS_W), .OFFSET_W(OFFSET_W), .SRC_W(SRC_W), .IDX_W(IDX_W),
    .DATA_W(DATA_W), .RAM_LATENCY(RAM_LATENCY), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs(req_vs), .req_offset(req_offset),
    .req_readSource(req_readSource), .req_instructionIndex(req_instructionIndex),
    .ram_ren(ram_ren), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_readSource(resp_readSource), .resp_instructionIndex(resp_instructionIndex),
    .idle(idle)
  );

  // SRAM model: data for a read enabled in cycle t is presented in cycle t+RAM_LATENCY.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [ADDR_W-1:0] sr_addr [RAM_LATENCY];
  logic              sr_vld  [RAM_LATENCY];

  always @(posedge clock) begin
    sr_vld[0]  <= ram_ren;
    sr_addr[0] <= ram_addr;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      sr_vld[i]  <= sr_vld[i-1];
      sr_addr[i] <= sr_addr[i-1];
    end
  end
  assign ram_rdata = sr_vld[RAM_LATENCY-1] ? mem[sr_addr[RAM_LATENCY-1]] : '0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [SRC_W-1:0]  s;
    logic [IDX_W-1:0]  i;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic stall_q = 1'b0;
  exp_t last_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops/compares responses, checks hold under backpressure, and
  // pushes the expected response for every accepted request.
  always @(negedge clock) begin
    if (!reset) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        chk("resp_hold_valid", 64'(resp_valid), 64'd1);
        chk("resp_hold_payload", 64'({resp_data, resp_readSource, resp_instructionIndex}),
            64'(last_resp));
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          chk("resp_data", 64'(resp_data), 64'(exp_q[0].d));
          chk("resp_readSource", 64'(resp_readSource), 64'(exp_q[0].s));
          chk("resp_instructionIndex", 64'(resp_instructionIndex), 64'(exp_q[0].i));
          void'(exp_q.pop_front());
        end
      end
      stall_q   <= resp_valid && !resp_ready;
      last_resp <= {resp_data, resp_readSource, resp_instructionIndex};
      if (req_valid && req_ready) begin
        chk("ram_ren_on_accept", 64'(ram_ren), 64'd1);
        chk("ram_addr_on_accept", 64'(ram_addr), 64'({req_vs, req_offset}));
        exp_q.push_back({mem[{req_vs, req_offset}], req_readSource, req_instructionIndex});
      end else begin
        chk("ram_ren_no_accept", 64'(ram_ren), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input int vs, input int off, input int s, input int ix);
    req_valid            = v;
    req_vs               = VS_W'(vs);
    req_offset           = OFFSET_W'(off);
    req_readSource       = SRC_W'(s);
    req_instructionIndex = IDX_W'(ix);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    resp_ready = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    for (int a = 0; a < (1 << ADDR_W); a++)
      mem[a] = (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    mem[11'h0C5] = 32'hDEAD_BEEF;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      sr_vld[i]  = 1'b0;
      sr_addr[i] = '0;
    end

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_ram_ren", 64'(ram_ren), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);

    // Single read
    tick();
    drive(1'b1, 3, 5, 2, 1);
    @(negedge clock);
    chk("t1_ram_ren", 64'(ram_ren), 64'd1);
    chk("t1_ram_addr", 64'(ram_addr), 64'h0C5);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk("t1_resp_latency", 64'(resp_valid), (k == 3) ? 64'd1 : 64'd0);
    end
    @(negedge clock);
    chk("t1_idle_after_pop", 64'(idle), 64'd1);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Streaming: 16 back-to-back requests, responses on consecutive cycles
    tick();
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          drive(1'b1, i + 7, i * 3 + 1, i, i + 2);
          chk("t2_req_ready", 64'(req_ready), 64'd1);
          tick();
        end
        req_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clock);
        while (!resp_valid && w < 20) begin
          @(negedge clock);
          w++;
        end
        for (int k = 0; k < 16; k++) begin
          chk("t2_resp_consecutive", 64'(resp_valid), 64'd1);
          @(negedge clock);
        end
        chk("t2_resp_stream_end", 64'(resp_valid), 64'd0);
      end
    join
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: only RESP_DEPTH requests accepted while resp_ready=0
    tick();
    resp_ready = 1'b0;
    begin
      int acc;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
        drive(1'b1, 20 + i, 40 + i, 8 + i, i);
        if (req_ready) acc++;
        tick();
      end
      req_valid = 1'b0;
      chk("t3_accepted", 64'(acc), 64'd4);
    end
    chk("t3_req_ready_low", 64'(req_ready), 64'd0);
    repeat (3) tick();
    chk("t3_resp_valid_full", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    @(negedge clock);
    chk("t3_req_ready_before_pop", 64'(req_ready), 64'd0);
    @(negedge clock);
    chk("t3_req_ready_after_pop", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clock);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_idle", 64'(idle), 64'd1);

    // Full FIFO, then accept and pop together
    tick();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 30 - i, 60 - i, i, 7 - i);
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    chk("t4_full_req_ready", 64'(req_ready), 64'd0);
    chk("t4_full_resp_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10 + i, 2 * i, 15 - i, i);
      chk("t4_req_ready", 64'(req_ready), (i == 0) ? 64'd0 : 64'd1);
      tick();
    end
    req_valid = 1'b0;
    repeat (8) tick();
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t4_idle", 64'(idle), 64'd1);

    // Reset while two reads are in flight
    drive(1'b1, 1, 1, 3, 3);
    tick();
    drive(1'b1, 2, 2, 4, 4);
    tick();
    req_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("t5_no_resp_after_reset", 64'(resp_valid), 64'd0);
    end
    chk("t5_idle", 64'(idle), 64'd1);
    chk("t5_req_ready", 64'(req_ready), 64'd1);

    // Random traffic with random backpressure
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      resp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    begin
      int w;
      w = 0;
      while ((exp_q.size() != 0 || !idle) && w < 50) begin
        tick();
        w++;
      end
    end
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_idle", 64'(idle), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
